alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes RV32M MUL (low 32 bits of the product) by sequencing the shared execute-stage ALU with shift-and-add.
- Drives the ALU's select and operand inputs and captures its result; uses ALU op 4'h1 (add) and 4'h2 (shift left logical).
- Sits beside the execute stage. It borrows the ALU only when alu_gnt is high and stalls otherwise.
- The low word is identical for signed and unsigned operands, so the block has no signedness input.

Parameters:
- XLEN, 32, operand/result width. The ALU select width is fixed at 4.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  multiply request present
- req_ready  output  1  block can accept a request
- req_a  input  XLEN  multiplicand
- req_b  input  XLEN  multiplier
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes the result
- resp_data  output  XLEN  low XLEN bits of req_a*req_b
- flush  input  1  pipeline kill; abort any operation
- alu_req  output  1  block needs the ALU this cycle
- alu_gnt  input  1  ALU granted to this block this cycle
- alu_sel  output  4  ALU operation select
- alu_op1  output  XLEN  ALU operand 1
- alu_op2  output  XLEN  ALU operand 2
- alu_result  input  XLEN  ALU combinational output

Behaviour:
- Internal registers: acc, mcand, mplier (all XLEN), count (6 bits).
- States: IDLE, EVAL, SHIFT, DONE.
- Reset values: state=IDLE, acc/mcand/mplier/count=0, req_ready=1, resp_valid=0, resp_data=0, alu_req=0, alu_sel=4'hF, alu_op1=0, alu_op2=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&!flush, load acc=0, mcand=req_a, mplier=req_b, count=0.
  - Next state is DONE if req_b==0, else EVAL.
- EVAL:
  - If mplier[0]=1: alu_req=1, alu_sel=4'h1, alu_op1=acc, alu_op2=mcand.
  - If alu_gnt=1, acc<=alu_result and go to SHIFT; else hold state and registers.
  - If mplier[0]=0: alu_req=0 and go to SHIFT unconditionally. acc is unchanged.
- SHIFT:
  - alu_req=1, alu_sel=4'h2, alu_op1=mcand, alu_op2=1.
  - If alu_gnt=1: mcand<=alu_result, mplier<=mplier>>1 (local logic, not the ALU), count<=count+1.
  - Then go to DONE if (mplier>>1)==0 or count+1==XLEN, else EVAL.
  - If alu_gnt=0: hold.
- DONE:
  - resp_valid=1, resp_data=acc. resp_data is stable while resp_valid=1.
  - On resp_ready go to IDLE.
- Whenever alu_req=0: alu_sel=4'hF, alu_op1=0, alu_op2=0.
- alu_req is combinational from state/mplier; alu_gnt may depend combinationally on alu_req.
- req_ready=1 only in IDLE. resp_valid=1 only in DONE.
- Latency with continuous grant:
  - Request accepted in cycle 0, highest set bit of req_b at position k: EVAL/SHIFT occupy cycles 1..2k+2, resp_valid rises in cycle 2k+3.
  - req_b==0: resp_valid in cycle 1.
  - Each cycle with alu_gnt=0 while alu_req=1 adds exactly one cycle.
- Arithmetic: all ALU results are truncated to XLEN; overflow of acc and mcand wraps silently.
- flush:
  - In any state, next state is IDLE and resp_valid=0 the following cycle.
  - alu_req is forced to 0 in the flush cycle and no register updates from alu_result.
  - flush overrides a simultaneous req_valid in IDLE (request not accepted) and a simultaneous resp_ready in DONE.
- reset mid-operation: same as the reset values above on the next edge; reset has priority over flush.
- Back-to-back: no new request is accepted in the cycle DONE→IDLE; the earliest acceptance is the following cycle.

Test Plan:
- 6×7, alu_gnt=1 constantly, accept at cycle 0 -> resp_valid at cycle 7, resp_data=42, req_ready low cycles 1–7.
- 0xFFFFFFFD×5 (−3×5) -> resp_data=0xFFFFFFF1, resp_valid at cycle 7. 0xFFFFFFFF×0xFFFFFFFF -> resp_data=0x00000001, resp_valid at cycle 65.
- 0x1234×0 -> resp_valid at cycle 1, resp_data=0, alu_req never asserted.
- 6×7 with alu_gnt=0 for 3 cycles during the first SHIFT -> alu_sel=4'h2, operands stable while stalled, resp_valid at cycle 10, resp_data=42.
- 6×7 with flush in cycle 3 -> IDLE at cycle 4 (req_ready=1), no resp_valid. A new 3×3 request then returns 9. flush plus req_valid in IDLE -> not accepted.
- DONE with resp_ready=0 for 5 cycles -> resp_valid/resp_data held. reset asserted in SHIFT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle low-word multiplier that borrows the shared execute-stage ALU
// for shift-and-add. It issues one add per set multiplier bit and one shift per bit.
module alu_mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    input  logic            flush,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_NONE = 4'hF;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [5:0]      r_count;

    logic [XLEN-1:0] w_mplier_next;
    logic [5:0]      w_count_next;
    logic            w_last_bit;

    assign w_mplier_next = r_mplier >> 1;
    assign w_count_next  = r_count + 6'd1;
    assign w_last_bit    = (w_mplier_next == '0) || (w_count_next == 6'(XLEN));

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = resp_valid ? r_acc : '0;

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_req = 1'b0;
        alu_sel = ALU_NONE;
        alu_op1 = '0;
        alu_op2 = '0;
        if (!flush) begin
            case (r_state)
                S_EVAL: begin
                    if (r_mplier[0]) begin
                        alu_req = 1'b1;
                        alu_sel = ALU_ADD;
                        alu_op1 = r_acc;
                        alu_op2 = r_mcand;
                    end
                end
                S_SHIFT: begin
                    alu_req = 1'b1;
                    alu_sel = ALU_SLL;
                    alu_op1 = r_mcand;
                    alu_op2 = XLEN'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= req_a;
                        r_mplier <= req_b;
                        r_count  <= '0;
                        r_state  <= (req_b == '0) ? S_DONE : S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (!r_mplier[0]) begin
                        r_state <= S_SHIFT;
                    end else if (alu_gnt) begin
                        r_acc   <= alu_result;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The multiplier shift is local; only the multiplicand uses the ALU.
                    if (alu_gnt) begin
                        r_mcand  <= alu_result;
                        r_mplier <= w_mplier_next;
                        r_count  <= w_count_next;
                        r_state  <= w_last_bit ? S_DONE : S_EVAL;
                    end
                end
                S_DONE: begin
                    if (resp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural add/shift ALU and
// a grant that can be withheld to exercise stalls.
module tb_alu_mul_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        flush;
    logic        alu_req;
    logic        alu_gnt;
    logic [3:0]  alu_sel;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        gnt_en;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mul_sequencer #(.XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .flush      (flush),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_sel    (alu_sel),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared execute-stage ALU: add and shift-left only.
    always_comb begin
        alu_result = 32'h0;
        case (alu_sel)
            4'h1:    alu_result = alu_op1 + alu_op2;
            4'h2:    alu_result = alu_op1 << alu_op2[4:0];
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_gnt = alu_req & gnt_en;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"},  resp_data,       32'h0);
        check({tag, "_alu_req"},    32'(alu_req),    32'd0);
        check({tag, "_alu_sel"},    32'(alu_sel),    32'hF);
        check({tag, "_alu_op1"},    alu_op1,         32'h0);
        check({tag, "_alu_op2"},    alu_op2,         32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Presents a request in the current cycle (cycle 0) and counts cycles until
    // resp_valid. Grant is withheld in cycles stall_lo..stall_hi.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_lo, input int stall_hi,
                          input logic [31:0] stall_op1,
                          output int lat, output logic [31:0] data,
                          output bit areq_seen, output bit rdy_bad, output bit stall_bad);
        lat = -1;
        data = 32'h0;
        areq_seen = 1'b0;
        rdy_bad = 1'b0;
        stall_bad = 1'b0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        for (int n = 1; n <= 100; n++) begin
            next_cycle();
            req_valid = 1'b0;
            gnt_en = !(n >= stall_lo && n <= stall_hi);
            @(negedge clock);
            if (resp_valid) begin
                lat = n;
                data = resp_data;
                break;
            end
            if (req_ready) rdy_bad = 1'b1;
            if (alu_req) areq_seen = 1'b1;
            if (n >= stall_lo && n <= stall_hi &&
                (alu_req !== 1'b1 || alu_sel !== 4'h2 || alu_op1 !== stall_op1 || alu_op2 !== 32'd1))
                stall_bad = 1'b1;
        end
        gnt_en = 1'b1;
        if (lat < 0) do_reset();
    endtask

    // Takes the response: DONE->IDLE cycle must not show req_ready, the next must.
    task automatic finish_resp(input string tag);
        next_cycle();
        resp_ready = 1'b1;
        @(negedge clock);
        check({tag, "_ready_in_handoff"}, 32'(req_ready), 32'd0);
        next_cycle();
        resp_ready = 1'b0;
        @(negedge clock);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        next_cycle();
    endtask

    initial begin
        int          lat;
        logic [31:0] data;
        bit          areq_seen, rdy_bad, stall_bad, bad;

        vecs[0] = '{32'd6,        32'd7,        32'd42,        7};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  7};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 65};
        vecs[3] = '{32'h1234,     32'd0,        32'h0,         1};
        vecs[4] = '{32'd3,        32'd3,        32'd9,         5};
        vecs[5] = '{32'd123,      32'd1,        32'd123,       3};
        vecs[6] = '{32'h00010000, 32'h00010000, 32'h0,        35};
        vecs[7] = '{32'h80000000, 32'h80000000, 32'h0,        65};
        vecs[8] = '{32'hDEADBEEF, 32'd3,        32'h9C093CCD,  5};

        reset = 1'b1;
        req_valid = 1'b0;
        req_a = 32'h0;
        req_b = 32'h0;
        resp_ready = 1'b0;
        flush = 1'b0;
        gnt_en = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("reset");
        next_cycle();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, -1, 32'h0, lat, data, areq_seen, rdy_bad, stall_bad);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_ready", i), 32'(rdy_bad), 32'd0);
            if (vecs[i].b == 32'h0)
                check($sformatf("vec%0d_no_alu_req", i), 32'(areq_seen), 32'd0);
            if (lat > 0) finish_resp($sformatf("vec%0d", i));
        end

        // Grant withheld during the first SHIFT (cycles 2..4) adds three cycles.
        run_op(32'd6, 32'd7, 2, 4, 32'd6, lat, data, areq_seen, rdy_bad, stall_bad);
        check("stall_data", data, 32'd42);
        check("stall_latency", 32'(lat), 32'd10);
        check("stall_operands_held", 32'(stall_bad), 32'd0);
        if (lat > 0) finish_resp("stall");

        // Consumer back-pressure: response held for five cycles.
        run_op(32'd100, 32'd200, 0, -1, 32'h0, lat, data, areq_seen, rdy_bad, stall_bad);
        check("hold_latency", 32'(lat), 32'd17);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_data !== 32'h4E20) bad = 1'b1;
        end
        check("hold_resp_stable", 32'(bad), 32'd0);
        if (lat > 0) finish_resp("hold");

        // Flush in cycle 3, where an add would otherwise be requested.
        req_valid = 1'b1;
        req_a = 32'd6;
        req_b = 32'd7;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        next_cycle();
        flush = 1'b1;
        @(negedge clock);
        check("flush_alu_req", 32'(alu_req), 32'd0);
        check("flush_alu_sel", 32'(alu_sel), 32'hF);
        next_cycle();
        flush = 1'b0;
        @(negedge clock);
        check("flush_idle_ready", 32'(req_ready), 32'd1);
        check("flush_no_resp", 32'(resp_valid), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clock);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        check("flush_stays_idle", 32'(bad), 32'd0);
        next_cycle();
        run_op(32'd3, 32'd3, 0, -1, 32'h0, lat, data, areq_seen, rdy_bad, stall_bad);
        check("after_flush_data", data, 32'd9);
        check("after_flush_latency", 32'(lat), 32'd5);
        if (lat > 0) finish_resp("after_flush");

        // Flush with a simultaneous request in IDLE: request is dropped.
        flush = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd5;
        req_b = 32'd5;
        next_cycle();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("flush_req_not_taken", 32'(req_ready), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clock);
            if (resp_valid !== 1'b0 || alu_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        check("flush_req_idle", 32'(bad), 32'd0);

        // Reset asserted while in SHIFT.
        next_cycle();
        req_valid = 1'b1;
        req_a = 32'd6;
        req_b = 32'd7;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        check("pre_reset_in_shift", 32'(alu_sel), 32'h2);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
